// File: rtl/mem_dma_engine_if.sv
// Memory-side bus of the DMA engine: one write port and two asynchronous read ports.
// The engine (master) drives addresses, enables and write data; the memory (slave)
// returns read data combinationally in the same cycle as the address.
interface mem_dma_engine_if #(
    parameter int ADDR_WIDTH = 10
);
    localparam int WIDX = ADDR_WIDTH - 2;

    logic [WIDX-1:0] mem_waddr;
    logic            mem_wren;
    logic [31:0]     mem_wdata;
    logic [WIDX-1:0] mem_raddr1;
    logic            mem_rden1;
    logic [31:0]     mem_rdata1;
    logic [WIDX-1:0] mem_raddr2;
    logic            mem_rden2;
    logic [31:0]     mem_rdata2;

    modport master (
        output mem_waddr, mem_wren, mem_wdata,
        output mem_raddr1, mem_rden1, mem_raddr2, mem_rden2,
        input  mem_rdata1, mem_rdata2
    );

    modport slave (
        input  mem_waddr, mem_wren, mem_wdata,
        input  mem_raddr1, mem_rden1, mem_raddr2, mem_rden2,
        output mem_rdata1, mem_rdata2
    );
endinterface

// File: rtl/mem_dma_engine.sv
// Block FILL / COPY / CMP engine driving an ideal memory, one word per cycle.
// Command handshake: start is a single-cycle strobe that is only looked at while the
// engine is idle (state_dbg == 0); a command is accepted at the edge where start=1 in
// IDLE with op != 11. busy is high while words are being moved, and done pulses for
// exactly one cycle when the command has finished. There is no back-pressure.
module mem_dma_engine #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [31:0]           fill_data,
    mem_dma_engine_if.master      mem,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic [LEN_WIDTH-1:0]  err_idx,
    output logic [LEN_WIDTH-1:0]  xfer_cnt,
    output logic [1:0]            state_dbg
);
    localparam int WIDX = ADDR_WIDTH - 2;

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [1:0]           op_q;
    logic [WIDX-1:0]      src_q;
    logic [WIDX-1:0]      dst_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [31:0]          fill_q;

    logic                 accept;
    logic                 run;
    logic                 cmp_diff;
    logic                 last_word;
    logic [WIDX-1:0]      ofs;
    logic [LEN_WIDTH-1:0] cnt_inc;

    assign accept    = (state == S_IDLE) && start && (op != OP_RSVD);
    assign run       = (state == S_RUN);
    // Word offset of the current access; addresses wrap silently at the top of memory.
    assign ofs       = xfer_cnt[WIDX-1:0];
    assign cnt_inc   = xfer_cnt + LEN_WIDTH'(1);
    assign cmp_diff  = run && (op_q == OP_CMP) && (mem.mem_rdata1 != mem.mem_rdata2);
    assign last_word = (cnt_inc == len_q);
    assign state_dbg = state;

    // Next-state decision: a zero-length command skips RUN, a CMP difference ends early.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = (len == '0) ? S_FIN : S_RUN;
            S_RUN:  if (cmp_diff || last_word) state_n = S_FIN;
            S_FIN:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Memory port drive: everything idles at zero outside RUN; writes are gated by reset.
    always_comb begin
        mem.mem_waddr  = '0;
        mem.mem_wren   = 1'b0;
        mem.mem_wdata  = '0;
        mem.mem_raddr1 = '0;
        mem.mem_rden1  = 1'b0;
        mem.mem_raddr2 = '0;
        mem.mem_rden2  = 1'b0;
        if (run) begin
            case (op_q)
                OP_FILL: begin
                    mem.mem_wren  = resetn;
                    mem.mem_waddr = dst_q + ofs;
                    mem.mem_wdata = fill_q;
                end
                OP_COPY: begin
                    mem.mem_rden1  = 1'b1;
                    mem.mem_raddr1 = src_q + ofs;
                    mem.mem_wren   = resetn;
                    mem.mem_waddr  = dst_q + ofs;
                    mem.mem_wdata  = mem.mem_rdata1;
                end
                OP_CMP: begin
                    mem.mem_rden1  = 1'b1;
                    mem.mem_raddr1 = src_q + ofs;
                    mem.mem_rden2  = 1'b1;
                    mem.mem_raddr2 = dst_q + ofs;
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    // Command latch, progress counter, sticky compare result and registered status.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            fill_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mismatch <= 1'b0;
            err_idx  <= '0;
            xfer_cnt <= '0;
        end else begin
            busy <= (state_n == S_RUN);
            done <= (state_n == S_FIN);
            if (accept) begin
                op_q     <= op;
                src_q    <= src_addr[ADDR_WIDTH-1:2];
                dst_q    <= dst_addr[ADDR_WIDTH-1:2];
                len_q    <= len;
                fill_q   <= fill_data;
                mismatch <= 1'b0;
                err_idx  <= '0;
                xfer_cnt <= '0;
            end else if (run) begin
                xfer_cnt <= cnt_inc;
                if (cmp_diff) begin
                    mismatch <= 1'b1;
                    err_idx  <= xfer_cnt;
                end
            end
        end
    end
endmodule

// File: doc/mem_dma_engine.md
Name: mem_dma_engine

Overview:
- Bus-initiator counterpart to the ideal memory. It drives the memory's write port and both read ports to fill, copy or compare blocks of 32-bit words without CPU involvement.
- Used by the evaluation top and simulation benches to preload, move and check data regions (for example, copy a region then verify it).
- Relies on the memory's asynchronous read (data valid in the same cycle) and synchronous write, so it moves one word per cycle.

Parameters:
- ADDR_WIDTH, 10: byte-address width of the memory. Word index width is ADDR_WIDTH-2.
- LEN_WIDTH, 9: width of the word-count field. Must satisfy LEN_WIDTH >= ADDR_WIDTH-1 so that a full-memory transfer fits.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- op  in  2  operation: 00 FILL, 01 COPY, 10 CMP, 11 reserved
- src_addr  in  ADDR_WIDTH  source byte address; bits [1:0] ignored
- dst_addr  in  ADDR_WIDTH  destination byte address; bits [1:0] ignored
- len  in  LEN_WIDTH  transfer length in words
- fill_data  in  32  pattern written by FILL
- mem_waddr  out  ADDR_WIDTH-2  word index to memory write port
- mem_wren  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_raddr1  out  ADDR_WIDTH-2  read port 1 word index (source)
- mem_rden1  out  1  read port 1 enable
- mem_rdata1  in  32  read port 1 data
- mem_raddr2  out  ADDR_WIDTH-2  read port 2 word index (destination, CMP only)
- mem_rden2  out  1  read port 2 enable
- mem_rdata2  in  32  read port 2 data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- mismatch  out  1  CMP found a difference; sticky until the next accepted start
- err_idx  out  LEN_WIDTH  word offset of the first mismatch
- xfer_cnt  out  LEN_WIDTH  words processed by the last or current command

Behaviour:
- Reset (resetn low at a clk edge):
  - State goes to IDLE. busy, done, mismatch, err_idx and xfer_cnt become 0.
  - All latched command fields become 0.
  - mem_wren is gated combinationally with resetn, so no write occurs at any edge where resetn is low, including reset mid-transfer. A partial transfer is abandoned.
- FSM states: IDLE, RUN, FIN.
  - IDLE: on start=1 with op != 11, latch op, word indices src=src_addr[ADDR_WIDTH-1:2] and dst=dst_addr[ADDR_WIDTH-1:2], len and fill_data. Clear mismatch, err_idx and xfer_cnt. Go to RUN if len != 0, else go to FIN.
  - IDLE with op=11: start is ignored; no state change.
  - start is ignored in RUN and FIN.
  - RUN: one word per cycle at offset i = xfer_cnt.
    - FILL: mem_wren=1, mem_waddr=dst+i, mem_wdata=fill_data.
    - COPY: mem_rden1=1, mem_raddr1=src+i, mem_wren=1, mem_waddr=dst+i, mem_wdata=mem_rdata1 (same cycle).
    - CMP: mem_rden1=1 and mem_rden2=1, raddr1=src+i, raddr2=dst+i, no write. If rdata1 != rdata2: set mismatch=1, err_idx=i, and go to FIN at the next edge.
    - xfer_cnt increments at each RUN edge, so it includes the mismatching word.
    - Go to FIN after the edge where xfer_cnt becomes len.
  - FIN: done=1 for exactly one cycle, busy=0, then return to IDLE.
- busy=1 in RUN. done and busy are registered.
- Outside RUN, all memory enables are 0 and addresses/wdata are 0.
- Latency: start accepted at edge T; the first access occurs in cycle T..T+1. A len=N transfer without mismatch has done high in cycle N+1 after acceptance. len=0 raises done one cycle after acceptance with zero memory accesses.
- Addresses: word index = base + i modulo 2^(ADDR_WIDTH-2), i.e. silent wrap at the top of memory.
- Overlap: processing is strictly ascending. A COPY with dst in (src, src+len) replicates the leading words; this is the defined result, not an error.
- After the command, mismatch, err_idx and xfer_cnt hold until the next accepted start or reset.

Test Plan:
- FILL: dst=0x0C8, len=25, fill=0xA5A5_0001 -> words 50..74 equal the pattern, word 49 and word 75 untouched, done 26 cycles after start, xfer_cnt=25.
- COPY then CMP: preload words 50..74, COPY src=0x0C8 dst=0x12C len=25, then CMP over the same regions -> words 75..99 match the source, mismatch=0, xfer_cnt=25.
- CMP with a corrupted word: dst word 75+7 altered -> mismatch=1, err_idx=7, xfer_cnt=8, done 9 cycles after start. A following accepted start clears mismatch.
- len=0 and op=11: len=0 gives done in the cycle after start with no wren/rden. op=11 leaves busy=0 and never raises done.
- Wrap and overlap:
  - FILL dst=0x3F8, len=4 -> writes words 254, 255, 0, 1.
  - COPY src=0 dst=4 len=4 over words 0..4 = {1,2,3,4,5} -> words 1..4 all equal 1.
- Reset mid-RUN and start-while-busy:
  - resetn low during word 3 of a len=10 FILL -> no write at the reset edge, words 3..9 unchanged, all outputs 0.
  - A start pulse while busy changes nothing.
